sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 32 +++
 rtl/sram_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter and its round-robin picker.
// Holds the arbiter state encoding and a pointer-width helper.
package sram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_REQ      = 3;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester at or above rr_ptr, wrapping to the lowest one.
// Purely combinational; winner is one-hot, or all-zero when nothing requests.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  winner
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] mask;
  logic [N-1:0] hi;

  // Lowest set bit of the upper window wins; otherwise the lowest set bit overall.
  always_comb begin
    mask   = '0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(rr_ptr));
    end
    hi = req & mask;
    if (|hi) begin
      winner = hi & (~hi + ONE);
    end else begin
      winner = req & (~req + ONE);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// N-way round-robin SRAM arbiter: access issued the cycle after req, read data one cycle later.
// Burst lock is enabled by SRAM_ARBITER_LOCK_EN; requesters hold req until granted.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_REQ      = DEF_N_REQ
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  input  logic [N_REQ-1:0]            lock,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        mem_cs,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_dout
);

  localparam int PW = ptr_width(N_REQ);

  arb_state              state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [N_REQ-1:0]      rvalid_q, rvalid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      pick;
  logic [N_REQ-1:0]      win;
  logic [PW-1:0]         win_idx;
  logic                  locked_win;
  logic                  win_lock;

  // The requester being served this cycle is masked so one request yields one grant.
  assign elig = req & ~gnt_q;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req    (elig),
    .rr_ptr (rr_ptr_q),
    .winner (pick)
  );

`ifdef SRAM_ARBITER_LOCK_EN
  // In LOCKED, gnt_q is the owner; it keeps winning while it holds both req and lock.
  assign locked_win = (state_q == ARB_LOCKED) && |(gnt_q & req & lock);
  assign win_lock   = |(win & lock);
`else
  logic unused_cfg;
  assign locked_win = 1'b0;
  assign win_lock   = 1'b0;
  assign unused_cfg = ^{lock, state_q};
`endif

  assign win = locked_win ? gnt_q : pick;

  always_comb begin
    state_d     = ARB_IDLE;
    rr_ptr_d    = rr_ptr_q;
    win_idx     = '0;
    gnt_d       = win;
    mem_we_d    = |(win & we);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx     = PW'(i);
        mem_addr_d  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_d = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (|win) begin
      state_d = win_lock ? ARB_LOCKED : ARB_ACCESS;
      // Pointer stays frozen while a lock owner re-wins.
      if (!locked_win) begin
        rr_ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
      end
    end
  end

  assign rvalid_d = mem_we_q ? '0 : gnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign mem_cs    = |gnt_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid    = rvalid_q;
  assign rdata     = (|rvalid_q) ? mem_dout : '0;

endmodule
